// File: rtl/serial_subtractor_pkg.sv
// Shared primitives for the serial subtractor.
//   state_t    : FSM state encodings (IDLE, BUSY, DONE)
//   full_adder : one-bit full adder, returns {carry_out, sum}
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One-bit full adder; result packed as {carry_out, sum}.
  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic cin);
    logic sum_s;
    logic cout_s;
    sum_s  = a ^ b ^ cin;
    cout_s = (a & b) | (a & cin) | (b & cin);
    return {cout_s, sum_s};
  endfunction

endpackage

// File: rtl/serial_subtractor_chunk.sv
// chunk_subtractor: combinational CHUNK_WIDTH-bit subtract slice, A + ~B + Cin.
// Ports:
//   A    : minuend chunk
//   B    : subtrahend chunk (inverted internally)
//   Cin  : carry in (1 = no borrow pending)
//   S    : difference chunk
//   Cout : carry out (0 = borrow out)
module chunk_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int CHUNK_WIDTH = 4
) (
  input  logic [CHUNK_WIDTH-1:0] A,
  input  logic [CHUNK_WIDTH-1:0] B,
  input  logic                   Cin,
  output logic [CHUNK_WIDTH-1:0] S,
  output logic                   Cout
);

  logic [CHUNK_WIDTH-1:0] sum_s;
  logic                   carry_s;
  logic [1:0]             fa_s;

  // Ripple chain of full adders; the running carry lives in a variable so
  // there is no self-referencing vector net.
  always_comb begin
    sum_s   = '0;
    carry_s = Cin;
    fa_s    = 2'b00;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      fa_s     = full_adder(A[i], ~B[i], carry_s);
      sum_s[i] = fa_s[0];
      carry_s  = fa_s[1];
    end
  end

  assign S    = sum_s;
  assign Cout = carry_s;

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes D = A - B - Bin one CHUNK_WIDTH slice per cycle.
// DATA_WIDTH must be an integer multiple of CHUNK_WIDTH.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake (ready only in IDLE)
//   A, B, Bin         : minuend, subtrahend, borrow in
//   out_valid/out_ready : result handshake (valid only in DONE)
//   D                 : difference, modulo 2^DATA_WIDTH
//   BF, VF, ZF        : borrow out, signed overflow, zero flag
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int CHUNK_WIDTH    = 4,
  parameter int OVERFLOW_LOGIC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] D,
  output logic                  BF,
  output logic                  VF,
  output logic                  ZF
);

  localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // Operands and result are viewed as arrays of chunks so the counter can
  // index them directly.
  typedef logic [N-1:0][CHUNK_WIDTH-1:0] chunks_t;

  state_t                 state_r;
  state_t                 next_state_s;
  chunks_t                a_r;
  chunks_t                b_r;
  chunks_t                d_r;
  chunks_t                d_next_s;
  logic [CNT_W-1:0]       cnt_r;
  logic                   carry_r;
  logic                   bf_r;
  logic                   vf_r;
  logic                   zf_r;
  logic [CHUNK_WIDTH-1:0] diff_s;
  logic                   cout_s;
  logic                   vf_next_s;

  chunk_subtractor #(
    .CHUNK_WIDTH(CHUNK_WIDTH)
  ) u_chunk (
    .A   (a_r[cnt_r]),
    .B   (b_r[cnt_r]),
    .Cin (carry_r),
    .S   (diff_s),
    .Cout(cout_s)
  );

  // Result with the active chunk merged in; used for D and for the flags
  // computed on the final chunk.
  always_comb begin
    d_next_s        = d_r;
    d_next_s[cnt_r] = diff_s;
  end

  assign vf_next_s = (OVERFLOW_LOGIC != 0) ?
                     ((a_r[N-1][CHUNK_WIDTH-1] != b_r[N-1][CHUNK_WIDTH-1]) &
                      (d_next_s[N-1][CHUNK_WIDTH-1] != a_r[N-1][CHUNK_WIDTH-1])) : 1'b0;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          next_state_s = ST_BUSY;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == CNT_LAST) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Datapath: operand capture in IDLE, one chunk per cycle in BUSY, flags
  // latched with the last chunk so they stay frozen throughout DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      d_r     <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      bf_r    <= 1'b0;
      vf_r    <= 1'b0;
      zf_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r     <= A;
            b_r     <= B;
            cnt_r   <= '0;
            carry_r <= ~Bin;
          end
        end
        ST_BUSY: begin
          d_r     <= d_next_s;
          carry_r <= cout_s;
          if (cnt_r != CNT_LAST) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            // Counter parks at the last chunk rather than wrapping.
            bf_r <= ~cout_s;
            zf_r <= (d_next_s == '0);
            vf_r <= vf_next_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign D         = d_r;
  assign BF        = bf_r;
  assign VF        = vf_r;
  assign ZF        = zf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  typedef struct packed {
    logic [15:0] d;
    logic        bf;
    logic        vf;
    logic        zf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] D;
  logic        BF;
  logic        VF;
  logic        ZF;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  serial_subtractor #(
    .DATA_WIDTH(16),
    .CHUNK_WIDTH(4),
    .OVERFLOW_LOGIC(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D        (D),
    .BF       (BF),
    .VF       (VF),
    .ZF       (ZF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: whenever a result is handed over, compare it with the oldest
  // expected entry.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got D=%h with no expected entry", D);
      end else begin
        mon_e = sb_q.pop_front();
        chk("D",  {16'h0, D},  {16'h0, mon_e.d});
        chk("BF", {31'h0, BF}, {31'h0, mon_e.bf});
        chk("VF", {31'h0, VF}, {31'h0, mon_e.vf});
        chk("ZF", {31'h0, ZF}, {31'h0, mon_e.zf});
      end
    end
  end

  // One operation. hold = cycles of back-pressure in DONE; pulse = drive a
  // second operand set during BUSY, which must be ignored.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input exp_t e, input int hold, input bit pulse);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("in_ready_before_op", {31'h0, in_ready}, 32'h1);
    A        = a;
    B        = b;
    Bin      = bin;
    in_valid = 1'b1;
    sb_q.push_back(e);
    if (hold > 0) out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (pulse && i == 1) begin
        chk("in_ready_busy", {31'h0, in_ready}, 32'h0);
        A        = 16'h0000;
        B        = 16'h0000;
        Bin      = 1'b1;
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("out_valid_latency", {31'h0, out_valid}, {31'h0, (i == 4)});
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'h0, out_valid}, 32'h1);
      chk("hold_D", {16'h0, D}, {16'h0, e.d});
      chk("hold_flags", {29'h0, BF, VF, ZF}, {29'h0, e.bf, e.vf, e.zf});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", {31'h0, in_ready}, 32'h1);
    chk("idle_out_valid", {31'h0, out_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = 16'h0;
    B         = 16'h0;
    Bin       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_D", {16'h0, D}, 32'h0);
    chk("reset_flags", {29'h0, BF, VF, ZF}, 32'h0);

    // Basic subtractions: {D, BF, VF, ZF}.
    do_op(16'h0005, 16'h0003, 1'b0, '{16'h0002, 1'b0, 1'b0, 1'b0}, 0, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0}, 0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1, 1'b0}, 0, 1'b0);
    do_op(16'h1234, 16'h1233, 1'b1, '{16'h0000, 1'b0, 1'b0, 1'b1}, 0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0}, 0, 1'b0);
    // Back-pressure for 5 cycles in DONE.
    do_op(16'h00FF, 16'h0F0F, 1'b0, '{16'hF1F0, 1'b1, 1'b0, 1'b0}, 5, 1'b0);
    // Operands pulsed during BUSY are ignored.
    do_op(16'h7FFF, 16'hFFFF, 1'b0, '{16'h8000, 1'b1, 1'b1, 1'b0}, 0, 1'b1);

    // Reset on the second BUSY cycle discards the operation.
    A        = 16'h4444;
    B        = 16'h1111;
    Bin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_test_busy", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_D", {16'h0, D}, 32'h0);
    chk("midrst_flags", {29'h0, BF, VF, ZF}, 32'h0);
    repeat (5) begin
      @(posedge clk); #1;
      chk("midrst_no_result", {31'h0, out_valid}, 32'h0);
    end
    do_op(16'hA000, 16'h2000, 1'b1, '{16'h7FFF, 1'b0, 1'b1, 1'b0}, 0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter DATA_WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter CHUNK_WIDTH, default 4: bits processed per cycle; DATA_WIDTH SHALL be an integer multiple of CHUNK_WIDTH.
REQ-003 Parameter OVERFLOW_LOGIC, default 1: 1 = VF computed; 0 = VF tied to 0.
REQ-004 Ports SHALL be:
- clk  input  1  sole clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- A  input  DATA_WIDTH  minuend.
- B  input  DATA_WIDTH  subtrahend.
- Bin  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- D  output  DATA_WIDTH  difference A - B - Bin.
- BF  output  1  borrow out (unsigned A < B + Bin).
- VF  output  1  signed overflow.
- ZF  output  1  D == 0.

Function
REQ-005 States SHALL be IDLE, BUSY and DONE; N = DATA_WIDTH/CHUNK_WIDTH.
REQ-006 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-007 IDLE: on in_valid & in_ready, register A, B, Bin; clear chunk counter; set carry register = ~Bin; go to BUSY.
REQ-008 BUSY: each cycle, compute chunk k as A_k + ~B_k + carry; write it to D bits [k*CHUNK_WIDTH +: CHUNK_WIDTH]; update carry; increment k.
REQ-009 After chunk N-1 is processed, the state SHALL go to DONE; out_valid SHALL rise exactly N cycles after the acceptance edge.
REQ-010 DONE: BF = ~final carry; ZF = (D == 0); VF = (A[msb] != B[msb]) & (D[msb] != A[msb]) when OVERFLOW_LOGIC = 1.
REQ-011 DONE: D, BF, VF and ZF SHALL be held stable while out_ready = 0.
REQ-012 DONE with out_ready = 1: return to IDLE on the next edge. No same-cycle re-accept; the earliest new acceptance is the following cycle.
REQ-013 in_valid asserted in BUSY or DONE SHALL be ignored and SHALL NOT alter the registered operands.
REQ-014 Arithmetic SHALL be modulo 2^DATA_WIDTH; the chunk counter SHALL NOT wrap past N-1.
REQ-015 D SHALL be updated only in BUSY.

Reset
REQ-016 On rst = 1 at a clock edge, from any state including mid-BUSY: state = IDLE, counter = 0, carry = 0, D = 0, BF = VF = ZF = 0, out_valid = 0. in_ready SHALL be 1 in the cycle after rst deasserts.
REQ-017 Any operation in flight at reset SHALL be discarded with no partial result presented.

Structure
REQ-018 State encodings (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2) SHALL live in a shared primitives header alongside full_adder.
REQ-019 One sub-module, chunk_subtractor, SHALL be used: combinational, CHUNK_WIDTH-bit, built from the existing full_adder primitive with B inverted; ports A, B, Cin, S, Cout.
REQ-020 The top level SHALL instantiate exactly one chunk_subtractor and select the active chunk using the counter.

Verification (DATA_WIDTH = 16, CHUNK_WIDTH = 4)
REQ-021 A = 0x0005, B = 0x0003, Bin = 0 -> after 4 cycles: D = 0x0002, BF = 0, VF = 0, ZF = 0.
REQ-022 A = 0x0000, B = 0x0001, Bin = 0 -> D = 0xFFFF, BF = 1, VF = 0. Then A = 0x8000, B = 0x0001 -> D = 0x7FFF, BF = 0, VF = 1.
REQ-023 A = 0x1234, B = 0x1233, Bin = 1 -> D = 0x0000, ZF = 1, BF = 0.
REQ-024 Back-pressure: out_ready = 0 for 5 cycles in DONE -> outputs stable and out_valid held. Then out_ready = 1 -> IDLE next cycle.
REQ-025 in_valid pulsed with new operands during BUSY -> ignored; result matches the first operands.
REQ-026 rst asserted on the 2nd BUSY cycle -> next cycle IDLE, all outputs 0, in_ready = 1. A new operation then completes correctly.
